// File: rtl/mem_port_arbiter_pkg.sv
// Shared processor definitions used by the data-memory port arbiter:
// memory depth, ROB tag width, FSM encoding and effective-address helper.
`ifndef ROB_SIZE_bits
`define ROB_SIZE_bits 4
`endif

package mem_port_arbiter_pkg;

    localparam int unsigned DM_DEPTH  = 1024;
    localparam int          ROB_TAG_W = `ROB_SIZE_bits + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // The extra bit keeps the carry so wrapped addresses are flagged invalid.
    function automatic logic [32:0] eff_addr(input logic [31:0] base,
                                             input logic [31:0] imm);
        return {1'b0, base} + {1'b0, imm};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, data-memory and response signals of the memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int ROBEN_W = mem_port_arbiter_pkg::ROB_TAG_W
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_store;
    logic [NREQ*32-1:0]      req_base;
    logic [NREQ*32-1:0]      req_imm;
    logic [NREQ*32-1:0]      req_data;
    logic [NREQ*ROBEN_W-1:0] req_roben;
    logic [NREQ-1:0]         grant;

    logic [31:0]             dm_address;
    logic [31:0]             dm_data;
    logic                    dm_read_en;
    logic                    dm_write_en;
    logic [ROBEN_W-1:0]      dm_roben;
    logic [31:0]             dm_result;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ROBEN_W-1:0]      rsp_roben;
    logic [31:0]             rsp_value;
    logic                    rsp_invalid;
    logic                    rsp_store;
    logic                    busy;

    modport slave (
        input  req_valid, req_store, req_base, req_imm, req_data, req_roben,
        input  dm_result, rsp_ready,
        output grant, dm_address, dm_data, dm_read_en, dm_write_en, dm_roben,
        output rsp_valid, rsp_roben, rsp_value, rsp_invalid, rsp_store, busy
    );

    modport master (
        output req_valid, req_store, req_base, req_imm, req_data, req_roben,
        output dm_result, rsp_ready,
        input  grant, dm_address, dm_data, dm_read_en, dm_write_en, dm_roben,
        input  rsp_valid, rsp_roben, rsp_value, rsp_invalid, rsp_store, busy
    );
endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_picker #(
    parameter  int NREQ  = 4,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] index,
    output logic             any
);
    always_comb begin
        int j;
        // NOTE: every output gets a default first so no path can infer a latch.
        j     = 0;
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                index    = PTR_W'(j);
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between NREQ load/store requesters, one
// operation in flight: IDLE (arbitrate) -> ACCESS (one cycle) -> RESP.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ROBEN_W   = ROB_TAG_W,
    parameter int MEM_DEPTH = DM_DEPTH
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NREQ);

    arb_state_e         state, state_n;
    logic [PTR_W-1:0]   rr_ptr, win_idx;
    logic [NREQ-1:0]    pick;
    logic               any_req, accept;

    logic [32:0]        win_sum;
    logic               win_store;
    logic [31:0]        win_data;
    logic [ROBEN_W-1:0] win_roben;

    logic               op_store, op_invalid;
    logic [31:0]        op_addr, op_data, rsp_value_q;
    logic [ROBEN_W-1:0] op_roben;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick),
        .index (win_idx),
        .any   (any_req)
    );

    always_comb begin
        int w;
        w         = int'(win_idx);
        win_sum   = eff_addr(bus.req_base[w*32 +: 32], bus.req_imm[w*32 +: 32]);
        win_store = bus.req_store[w];
        win_data  = bus.req_data[w*32 +: 32];
        win_roben = bus.req_roben[w*ROBEN_W +: ROBEN_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking so every register samples values from before the edge.
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        unique case (state)
            ST_IDLE:   if (any_req) begin
                           accept  = 1'b1;
                           state_n = ST_ACCESS;
                       end
            ST_ACCESS: state_n = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // NOTE: these registers drive outputs directly, so they are all reset to
    // give clean zeros on the bus the moment reset asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            op_store    <= 1'b0;
            op_invalid  <= 1'b0;
            op_addr     <= '0;
            op_data     <= '0;
            op_roben    <= '0;
            rsp_value_q <= '0;
        end else begin
            if (accept) begin
                rr_ptr     <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                op_store   <= win_store;
                op_invalid <= (win_sum >= 33'(MEM_DEPTH));
                op_addr    <= win_sum[31:0];
                op_data    <= win_data;
                op_roben   <= win_roben;
            end
            if (state == ST_ACCESS)
                rsp_value_q <= bus.dm_read_en ? bus.dm_result : '0;
        end
    end

    // Grant is combinational in IDLE; gating with rst keeps it quiet in reset.
    assign bus.grant       = (accept && rst) ? pick : '0;
    assign bus.busy        = (state != ST_IDLE);

    assign bus.dm_address  = op_addr;
    assign bus.dm_data     = op_data;
    assign bus.dm_roben    = op_roben;
    assign bus.dm_read_en  = (state == ST_ACCESS) && !op_store && !op_invalid;
    assign bus.dm_write_en = (state == ST_ACCESS) &&  op_store && !op_invalid;

    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.rsp_roben   = op_roben;
    assign bus.rsp_value   = rsp_value_q;
    assign bus.rsp_invalid = op_invalid;
    assign bus.rsp_store   = op_store;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed operations push expected
// grants, memory accesses and responses; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int RW   = ROB_TAG_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NREQ(NREQ), .ROBEN_W(RW)) bus ();

    mem_port_arbiter #(.NREQ(NREQ), .ROBEN_W(RW), .MEM_DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word memory preloaded with 0x1000_0000 + address.
    logic [31:0] mem [0:1023];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
            mem_loaded <= 1'b1;
        end else if (bus.dm_write_en) begin
            mem[bus.dm_address[9:0]] <= bus.dm_data;
        end
    end
    assign bus.dm_result = mem[bus.dm_address[9:0]];

    typedef struct {
        logic [31:0]   addr;
        logic [31:0]   data;
        logic          we;
        logic [RW-1:0] tag;
    } acc_t;

    typedef struct {
        logic [RW-1:0] tag;
        logic [31:0]   value;
        logic          invalid;
        logic          store;
    } rsp_t;

    logic [NREQ-1:0] exp_gnt [$];
    acc_t            exp_acc [$];
    rsp_t            exp_rsp [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_event(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: compares every grant, memory access and accepted response.
    initial begin
        acc_t a;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.grant != '0) begin
                    if (exp_gnt.size() == 0) fail_event("grant", "got a grant, expected none");
                    else check("grant", 64'(bus.grant), 64'(exp_gnt.pop_front()));
                end
                if (bus.dm_read_en || bus.dm_write_en) begin
                    if (exp_acc.size() == 0) fail_event("dm_access", "got an enable, expected none");
                    else begin
                        a = exp_acc.pop_front();
                        check("dm_address",  64'(bus.dm_address),  64'(a.addr));
                        check("dm_write_en", 64'(bus.dm_write_en), 64'(a.we));
                        check("dm_read_en",  64'(bus.dm_read_en),  64'(!a.we));
                        check("dm_roben",    64'(bus.dm_roben),    64'(a.tag));
                        if (a.we) check("dm_data", 64'(bus.dm_data), 64'(a.data));
                    end
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_rsp.size() == 0) fail_event("rsp", "got a response, expected none");
                    else begin
                        r = exp_rsp.pop_front();
                        check("rsp_roben",   64'(bus.rsp_roben),   64'(r.tag));
                        check("rsp_value",   64'(bus.rsp_value),   64'(r.value));
                        check("rsp_invalid", 64'(bus.rsp_invalid), 64'(r.invalid));
                        check("rsp_store",   64'(bus.rsp_store),   64'(r.store));
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic st, input logic [31:0] base,
                           input logic [31:0] imm, input logic [31:0] data,
                           input logic [RW-1:0] tag);
        bus.req_store[i]            = st;
        bus.req_base[i*32 +: 32]    = base;
        bus.req_imm[i*32 +: 32]     = imm;
        bus.req_data[i*32 +: 32]    = data;
        bus.req_roben[i*RW +: RW]   = tag;
        bus.req_valid[i]            = 1'b1;
    endtask

    task automatic expect_op(input logic [NREQ-1:0] gnt, input logic st,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [RW-1:0] tag, input logic acc,
                             input logic [31:0] value, input logic inv);
        acc_t a;
        rsp_t r;
        exp_gnt.push_back(gnt);
        if (acc) begin
            a.addr = addr; a.data = data; a.we = st; a.tag = tag;
            exp_acc.push_back(a);
        end
        r.tag = tag; r.value = value; r.invalid = inv; r.store = st;
        exp_rsp.push_back(r);
    endtask

    // Waits for requester i to be granted, then drops its request.
    task automatic wait_grant(input int i);
        int n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (bus.grant[i]) break;
            n++;
        end
        if (n >= 40) fail_event("grant_wait", "no grant within 40 cycles, expected one");
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (n < 40 && (exp_rsp.size() != 0 || bus.busy)) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) fail_event("idle_wait", "still busy after 40 cycles, expected idle");
    endtask

    task automatic issue(input int i, input logic st, input logic [31:0] base,
                         input logic [31:0] imm, input logic [31:0] data,
                         input logic [RW-1:0] tag, input logic [NREQ-1:0] gnt,
                         input logic [31:0] addr, input logic acc,
                         input logic [31:0] value, input logic inv);
        expect_op(gnt, st, addr, data, tag, acc, value, inv);
        set_req(i, st, base, imm, data, tag);
        wait_grant(i);
    endtask

    initial begin
        int seen;
        int k;
        int gk [5];

        bus.req_valid = '0;
        bus.req_store = '0;
        bus.req_base  = '0;
        bus.req_imm   = '0;
        bus.req_data  = '0;
        bus.req_roben = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk); #1;
        check("rst_busy",      64'(bus.busy),       64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid),  64'd0);
        check("rst_read_en",   64'(bus.dm_read_en), 64'd0);
        rst = 1'b1;

        // No request pending: stays idle, no grant.
        repeat (3) begin
            @(negedge clk);
            check("idle_grant", 64'(bus.grant), 64'd0);
            check("idle_busy",  64'(bus.busy),  64'd0);
        end
        @(posedge clk); #1;

        // Single load, then store/load through the same word.
        issue(0, 1'b0, 32'd100, 32'd4, 32'd0, RW'(5), 4'b0001, 32'd104, 1'b1, 32'h1000_0068, 1'b0);
        wait_idle();
        issue(1, 1'b1, 32'd200, 32'd16, 32'hDEAD_BEEF, RW'(6), 4'b0010, 32'd216, 1'b1, 32'd0, 1'b0);
        issue(2, 1'b0, 32'd216, 32'd0, 32'd0, RW'(7), 4'b0100, 32'd216, 1'b1, 32'hDEAD_BEEF, 1'b0);
        wait_idle();

        // Address range boundaries: beyond depth, carry out, last valid word.
        issue(3, 1'b1, 32'd1020, 32'd8, 32'h55, RW'(8), 4'b1000, 32'd0, 1'b0, 32'd0, 1'b1);
        issue(0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, RW'(9), 4'b0001, 32'd0, 1'b0, 32'd0, 1'b1);
        issue(1, 1'b0, 32'd1000, 32'd23, 32'd0, RW'(10), 4'b0010, 32'd1023, 1'b1, 32'h1000_03FF, 1'b0);
        wait_idle();

        // Reset in the middle of a store's ACCESS cycle.
        exp_gnt.push_back(4'b0100);
        set_req(2, 1'b1, 32'd50, 32'd0, 32'h1234, RW'(11));
        wait_grant(2);
        check("pre_rst_write_en", 64'(bus.dm_write_en), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_write_en", 64'(bus.dm_write_en), 64'd0);
        check("mid_rst_read_en",  64'(bus.dm_read_en),  64'd0);
        check("mid_rst_busy",     64'(bus.busy),        64'd0);
        check("mid_rst_address",  64'(bus.dm_address),  64'd0);
        check("mid_rst_data",     64'(bus.dm_data),     64'd0);
        check("mid_rst_dm_roben", 64'(bus.dm_roben),    64'd0);
        check("mid_rst_rsp_valid",64'(bus.rsp_valid),   64'd0);
        check("mid_rst_rsp_value",64'(bus.rsp_value),   64'd0);
        check("mid_rst_rsp_roben",64'(bus.rsp_roben),   64'd0);
        repeat (2) @(posedge clk); #1;
        check("no_write_mem50", 64'(mem[50]), 64'h1000_0032);

        // All four requesting continuously from reset release.
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b0, 32'(i * 8), 32'd1, 32'd0, RW'(12 + i));
        expect_op(4'b0001, 1'b0, 32'd1,  32'd0, RW'(12), 1'b1, 32'h1000_0001, 1'b0);
        expect_op(4'b0010, 1'b0, 32'd9,  32'd0, RW'(13), 1'b1, 32'h1000_0009, 1'b0);
        expect_op(4'b0100, 1'b0, 32'd17, 32'd0, RW'(14), 1'b1, 32'h1000_0011, 1'b0);
        expect_op(4'b1000, 1'b0, 32'd25, 32'd0, RW'(15), 1'b1, 32'h1000_0019, 1'b0);
        expect_op(4'b0001, 1'b0, 32'd1,  32'd0, RW'(12), 1'b1, 32'h1000_0001, 1'b0);
        rst  = 1'b1;
        seen = 0;
        k    = 0;
        while (seen < 5 && k < 60) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                gk[seen] = k;
                seen++;
            end
            k++;
        end
        if (seen < 5) fail_event("rr_grants", "fewer than 5 grants within 60 cycles");
        @(posedge clk); #1;
        bus.req_valid = '0;
        check("first_grant_cycle", 64'(gk[0]), 64'd0);
        for (int i = 1; i < 5; i++)
            check("grant_spacing", 64'(gk[i] - gk[i-1]), 64'd3);
        wait_idle();

        // Response back-pressure with another requester waiting.
        bus.rsp_ready = 1'b0;
        issue(1, 1'b0, 32'd300, 32'd0, 32'd0, RW'(3), 4'b0010, 32'd300, 1'b1, 32'h1000_012C, 1'b0);
        expect_op(4'b0100, 1'b0, 32'd400, 32'd0, RW'(4), 1'b1, 32'h1000_0190, 1'b0);
        set_req(2, 1'b0, 32'd400, 32'd0, 32'd0, RW'(4));
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.rsp_valid) fail_event("stall_wait", "rsp_valid never rose, expected 1");
        repeat (5) begin
            @(negedge clk);
            check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("stall_busy",      64'(bus.busy),      64'd1);
            check("stall_grant",     64'(bus.grant),     64'd0);
            check("stall_rsp_roben", 64'(bus.rsp_roben), 64'd3);
            check("stall_rsp_value", 64'(bus.rsp_value), 64'h1000_012C);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_grant(2);
        wait_idle();

        check("mem216_stored",   64'(mem[216]),        64'hDEAD_BEEF);
        check("gnt_queue_empty", 64'(exp_gnt.size()),  64'd0);
        check("acc_queue_empty", 64'(exp_acc.size()),  64'd0);
        check("rsp_queue_empty", 64'(exp_rsp.size()),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200us, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
